// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the fp_cmp_pipe comparator: op codes, operand classes
// and the canonical quiet-NaN builder.
package fp_cmp_pkg;

   localparam logic [2:0] OP_GT  = 3'd0;
   localparam logic [2:0] OP_GE  = 3'd1;
   localparam logic [2:0] OP_LT  = 3'd2;
   localparam logic [2:0] OP_LE  = 3'd3;
   localparam logic [2:0] OP_EQ  = 3'd4;
   localparam logic [2:0] OP_NE  = 3'd5;
   localparam logic [2:0] OP_MAX = 3'd6;
   localparam logic [2:0] OP_MIN = 3'd7;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_DEN,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } cls_e;

   localparam int QNAN_MAX_W = 128;

   // {0, all-ones exponent, mantissa MSB set, rest zero}; callers slice to their width.
   function automatic logic [QNAN_MAX_W-1:0] qnan_bits(input int exp_w, input int man_w);
      logic [QNAN_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < QNAN_MAX_W; i++) begin
         if (i >= man_w - 1 && i < man_w + exp_w) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_cmp_classify.sv
// Operand classifier: decodes zero/denormal/normal/inf/NaN and, when
// FP_CMP_DAZ_EN is defined, flushes denormals to a signed zero.
module fp_cmp_classify
   import fp_cmp_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic [W-1:0] value,
   output cls_e         cls,
   output logic [W-1:0] value_adj
);

   logic [EXP_W-1:0] exp_f;
   logic [MAN_W-1:0] man_f;

   assign exp_f = value[W-2:MAN_W];
   assign man_f = value[MAN_W-1:0];

   always_comb begin
      cls       = CLS_NORM;
      value_adj = value;
      if (exp_f == '0) begin
         cls = (man_f == '0) ? CLS_ZERO : CLS_DEN;
      end else if (&exp_f) begin
         cls = (man_f == '0) ? CLS_INF : CLS_NAN;
      end
`ifdef FP_CMP_DAZ_EN
      if (exp_f == '0 && man_f != '0) begin
         cls       = CLS_ZERO;
         value_adj = {value[W-1], {(W-1){1'b0}}};
      end
`else
`endif
   end

endmodule

// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined floating-point comparator / min-max with valid-ready
// handshake. Define FP_CMP_DAZ_EN to treat denormal inputs as signed zero.
module fp_cmp_pipe
   import fp_cmp_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [2:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_flag,
   output logic [W-1:0] out_val,
   output logic         out_unord
);

   localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));

   cls_e         cls_a, cls_b;
   logic [W-1:0] adj_a, adj_b;

   fp_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .value     (in_a),
      .cls       (cls_a),
      .value_adj (adj_a)
   );

   fp_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .value     (in_b),
      .cls       (cls_b),
      .value_adj (adj_b)
   );

   logic         s1_valid;
   logic [W-1:0] s1_a, s1_b;
   logic [2:0]   s1_op;
   cls_e         s1_cls_a, s1_cls_b;
   logic         s1_adv, s2_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_GT;
         s1_cls_a <= CLS_ZERO;
         s1_cls_b <= CLS_ZERO;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a     <= adj_a;
            s1_b     <= adj_b;
            s1_op    <= in_op;
            s1_cls_a <= cls_a;
            s1_cls_b <= cls_b;
         end
      end
   end

   logic         a_nan, b_nan, unord, both_zero;
   logic         a_lt_b, a_eq_b, a_gt_b, is_max;
   logic         nx_flag;
   logic [W-1:0] nx_val, sel;

   assign a_nan     = (s1_cls_a == CLS_NAN);
   assign b_nan     = (s1_cls_b == CLS_NAN);
   assign unord     = a_nan || b_nan;
   assign both_zero = (s1_cls_a == CLS_ZERO) && (s1_cls_b == CLS_ZERO);
   assign is_max    = (s1_op == OP_MAX);

   // Ordering ignores NaN; those cases are overridden by unord below.
   always_comb begin
      a_eq_b = both_zero || (s1_a == s1_b);
      if (both_zero)
         a_lt_b = 1'b0;
      else if (s1_a[W-1] != s1_b[W-1])
         a_lt_b = s1_a[W-1];
      else if (s1_a[W-1])
         a_lt_b = (s1_a[W-2:0] > s1_b[W-2:0]);
      else
         a_lt_b = (s1_a[W-2:0] < s1_b[W-2:0]);
      a_gt_b = !a_lt_b && !a_eq_b;
   end

   always_comb begin
      sel = s1_a;
      if (a_nan && b_nan)
         sel = QNAN;
      else if (a_nan)
         sel = s1_b;
      else if (b_nan)
         sel = s1_a;
      else if (both_zero)
         sel = ((is_max ? !s1_a[W-1] : s1_a[W-1])) ? s1_a : s1_b;
      else if (a_eq_b)
         sel = s1_a;
      else
         sel = (is_max ? a_gt_b : a_lt_b) ? s1_a : s1_b;
   end

   always_comb begin
      nx_flag = 1'b0;
      nx_val  = '0;
      case (s1_op)
         OP_GT:   nx_flag = !unord && a_gt_b;
         OP_GE:   nx_flag = !unord && (a_gt_b || a_eq_b);
         OP_LT:   nx_flag = !unord && a_lt_b;
         OP_LE:   nx_flag = !unord && (a_lt_b || a_eq_b);
         OP_EQ:   nx_flag = !unord && a_eq_b;
         OP_NE:   nx_flag = unord || !a_eq_b;
         default: nx_val  = sel;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_flag  <= 1'b0;
         out_val   <= '0;
         out_unord <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_flag  <= nx_flag;
            out_val   <= nx_val;
            out_unord <= unord;
         end
      end
   end

endmodule
